// File: rtl/spongent_msg_feeder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spongent_msg_feeder_pkg
//  Description : Shared constants, helper functions and FSM state encoding
//                for the SPONGENT byte-stream message feeder.
//  Revision    : 1.0 - initial release
// ============================================================================
package spongent_msg_feeder_pkg;

    // First byte of 10* padding
    localparam logic [7:0] PAD_BYTE = 8'h80;

    localparam int DEFAULT_RATE        = 16;
    localparam int DEFAULT_DIGEST_SIZE = 128;

    function automatic int bytes_per_block(input int rate);
        return rate / 8;
    endfunction

    function automatic int num_squeeze(input int rate, input int digest_size);
        return digest_size / rate;
    endfunction

    localparam int BYTES_PER_BLOCK = bytes_per_block(DEFAULT_RATE);
    localparam int NUM_SQUEEZE     = num_squeeze(DEFAULT_RATE, DEFAULT_DIGEST_SIZE);

    // One-hot feeder states
    localparam int ST_W = 13;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE       = 13'b0000000000001,
        ST_CLEAR      = 13'b0000000000010,
        ST_SETTLE     = 13'b0000000000100,
        ST_FILL       = 13'b0000000001000,
        ST_PAD        = 13'b0000000010000,
        ST_ABS_START  = 13'b0000000100000,
        ST_ABS_ACK    = 13'b0000001000000,
        ST_ABS_WAIT   = 13'b0000010000000,
        ST_SQ_CAPTURE = 13'b0000100000000,
        ST_SQ_START   = 13'b0001000000000,
        ST_SQ_ACK     = 13'b0010000000000,
        ST_SQ_WAIT    = 13'b0100000000000,
        ST_DONE       = 13'b1000000000000
    } feeder_state_t;

endpackage
`default_nettype wire

// File: rtl/spongent_block_packer.sv
`default_nettype none
// ============================================================================
//  Module      : spongent_block_packer
//  Description : Packs message bytes MSB-first into a RATE-bit block, inserts
//                10* padding and loads the standalone pad block.
//  Revision    : 1.0 - initial release
// ============================================================================
module spongent_block_packer
    import spongent_msg_feeder_pkg::*;
#(
    parameter int RATE = DEFAULT_RATE
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    input  logic            wr_en,
    input  logic [7:0]      wr_data,
    input  logic            pad_en,
    input  logic            load_pad,
    output logic [RATE-1:0] block,
    output logic            last_slot
);

    localparam int BPB   = bytes_per_block(RATE);
    localparam int CNT_W = $clog2(BPB) + 1;
    localparam logic [RATE-1:0] PAD_BLOCK = RATE'(PAD_BYTE) << (RATE - 8);

    logic [RATE-1:0]  r_block;
    logic [CNT_W-1:0] r_count;

    // The byte about to be written completes the block
    assign last_slot = (r_count == CNT_W'(BPB - 1));
    assign block     = r_block;

    // Byte buffer and write position; pad clears every byte after the marker
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_block <= '0;
            r_count <= '0;
        end else if (load_pad) begin
            r_block <= PAD_BLOCK;
            r_count <= '0;
        end else if (pad_en) begin
            for (int b = 0; b < BPB; b++) begin
                if (b == int'(r_count)) begin
                    r_block[RATE-1-8*b -: 8] <= PAD_BYTE;
                end else if (b > int'(r_count)) begin
                    r_block[RATE-1-8*b -: 8] <= 8'h00;
                end
            end
            r_count <= '0;
        end else if (wr_en) begin
            for (int b = 0; b < BPB; b++) begin
                if (b == int'(r_count)) begin
                    r_block[RATE-1-8*b -: 8] <= wr_data;
                end
            end
            r_count <= last_slot ? '0 : r_count + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/spongent_msg_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : spongent_msg_feeder
//  Description : Byte-stream front end for the SPONGENT core. Packs and pads
//                message blocks, sequences absorbs and squeezes, and collects
//                the digest.
//  Revision    : 1.0 - initial release
// ============================================================================
module spongent_msg_feeder
    import spongent_msg_feeder_pkg::*;
#(
    parameter int RATE        = DEFAULT_RATE,
    parameter int DIGEST_SIZE = DEFAULT_DIGEST_SIZE
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [7:0]             in_data,
    input  logic                   in_last,
    output logic                   core_clear,
    output logic                   core_start,
    output logic                   core_msg_avail,
    input  logic                   core_busy,
    output logic [RATE-1:0]        block_out,
    input  logic [RATE-1:0]        core_rate_out,
    output logic [DIGEST_SIZE-1:0] digest,
    output logic                   digest_valid,
    output logic                   busy
);

    localparam int NSQ  = num_squeeze(RATE, DIGEST_SIZE);
    localparam int SQ_W = $clog2(NSQ) + 1;

    feeder_state_t          r_state;
    feeder_state_t          w_state_next;
    logic                   r_settle_cnt;
    logic                   r_pad_pending;
    logic                   r_final;
    logic [SQ_W-1:0]        r_sq_count;
    logic [DIGEST_SIZE-1:0] r_digest;
    logic [DIGEST_SIZE-1:0] w_digest_shifted;

    logic w_pk_clear;
    logic w_pk_wr;
    logic w_pk_pad;
    logic w_pk_load_pad;
    logic w_last_slot;
    logic w_set_pad_pending;
    logic w_clr_pad_pending;
    logic w_set_final;
    logic w_capture;

    spongent_block_packer #(
        .RATE (RATE)
    ) u_packer (
        .clk       (clk),
        .reset     (reset),
        .clear     (w_pk_clear),
        .wr_en     (w_pk_wr),
        .wr_data   (in_data),
        .pad_en    (w_pk_pad),
        .load_pad  (w_pk_load_pad),
        .block     (block_out),
        .last_slot (w_last_slot)
    );

    // Newest squeezed block enters at the LSBs so the first one ends up on top
    if (DIGEST_SIZE == RATE) begin : g_digest_single
        assign w_digest_shifted = core_rate_out;
    end else begin : g_digest_multi
        assign w_digest_shifted = {r_digest[DIGEST_SIZE-RATE-1:0], core_rate_out};
    end

    // Moore outputs decoded from the current state
    assign in_ready       = (r_state == ST_FILL);
    assign core_clear     = (r_state == ST_CLEAR);
    assign core_start     = (r_state == ST_ABS_START) || (r_state == ST_SQ_START);
    assign core_msg_avail = (r_state == ST_ABS_START);
    assign digest_valid   = (r_state == ST_DONE);
    assign busy           = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign digest         = r_digest;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and datapath strobes
    always_comb begin
        w_state_next      = r_state;
        w_pk_clear        = 1'b0;
        w_pk_wr           = 1'b0;
        w_pk_pad          = 1'b0;
        w_pk_load_pad     = 1'b0;
        w_set_pad_pending = 1'b0;
        w_clr_pad_pending = 1'b0;
        w_set_final       = 1'b0;
        w_capture         = 1'b0;
        unique case (r_state)
            ST_IDLE, ST_DONE: begin
                if (in_valid) w_state_next = ST_CLEAR;
            end
            ST_CLEAR: begin
                w_pk_clear   = 1'b1;
                w_state_next = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (r_settle_cnt) w_state_next = ST_FILL;
            end
            ST_FILL: begin
                if (in_valid) begin
                    w_pk_wr = 1'b1;
                    if (w_last_slot) begin
                        // Full block with the final byte: the pad needs a block of its own
                        w_set_pad_pending = in_last;
                        w_state_next      = ST_ABS_START;
                    end else if (in_last) begin
                        w_state_next = ST_PAD;
                    end
                end
            end
            ST_PAD: begin
                w_pk_pad     = 1'b1;
                w_set_final  = 1'b1;
                w_state_next = ST_ABS_START;
            end
            ST_ABS_START: w_state_next = ST_ABS_ACK;
            ST_ABS_ACK: begin
                if (core_busy) w_state_next = ST_ABS_WAIT;
            end
            ST_ABS_WAIT: begin
                if (!core_busy) begin
                    if (r_pad_pending) begin
                        w_pk_load_pad     = 1'b1;
                        w_clr_pad_pending = 1'b1;
                        w_set_final       = 1'b1;
                        w_state_next      = ST_ABS_START;
                    end else if (r_final) begin
                        w_state_next = ST_SQ_CAPTURE;
                    end else begin
                        w_pk_clear   = 1'b1;
                        w_state_next = ST_FILL;
                    end
                end
            end
            ST_SQ_CAPTURE: begin
                w_capture = 1'b1;
                if (r_sq_count == SQ_W'(NSQ - 1)) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next = ST_SQ_START;
                end
            end
            ST_SQ_START: w_state_next = ST_SQ_ACK;
            ST_SQ_ACK: begin
                if (core_busy) w_state_next = ST_SQ_WAIT;
            end
            ST_SQ_WAIT: begin
                if (!core_busy) w_state_next = ST_SQ_CAPTURE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Per-message bookkeeping: settle timer, pad/final flags, squeeze count, digest
    always_ff @(posedge clk) begin
        if (reset) begin
            r_settle_cnt  <= 1'b0;
            r_pad_pending <= 1'b0;
            r_final       <= 1'b0;
            r_sq_count    <= '0;
            r_digest      <= '0;
        end else begin
            r_settle_cnt <= (r_state == ST_SETTLE) ? ~r_settle_cnt : 1'b0;
            if (r_state == ST_CLEAR) begin
                r_pad_pending <= 1'b0;
                r_final       <= 1'b0;
                r_sq_count    <= '0;
                r_digest      <= '0;
            end else begin
                if (w_set_pad_pending) begin
                    r_pad_pending <= 1'b1;
                end else if (w_clr_pad_pending) begin
                    r_pad_pending <= 1'b0;
                end
                if (w_set_final) r_final <= 1'b1;
                if (w_capture) begin
                    r_digest   <= w_digest_shifted;
                    r_sq_count <= r_sq_count + SQ_W'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spongent_msg_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spongent_msg_feeder
//  Description : Self-checking bench for spongent_msg_feeder with a toy core
//                model and a message-level reference (10* padding + sponge).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spongent_msg_feeder;

    localparam int RATE  = 16;
    localparam int DSZ   = 128;
    localparam int BPB   = RATE / 8;
    localparam int NSQ   = DSZ / RATE;
    localparam int BOUND = 5000;

    typedef logic [7:0]  byteq_t[$];
    typedef logic [15:0] blkq_t[$];

    typedef struct {
        int          len;
        logic [31:0] bytes;
        int          nblk;
        logic [47:0] blks;
        int          hold;
    } vec_t;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [7:0]      in_data;
    logic            in_last;
    logic            core_clear;
    logic            core_start;
    logic            core_msg_avail;
    logic            core_busy;
    logic [RATE-1:0] block_out;
    logic [RATE-1:0] core_rate_out;
    logic [DSZ-1:0]  digest;
    logic            digest_valid;
    logic            busy;

    int n_checks = 0;
    int n_pass   = 0;

    spongent_msg_feeder #(
        .RATE        (RATE),
        .DIGEST_SIZE (DSZ)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .in_last        (in_last),
        .core_clear     (core_clear),
        .core_start     (core_start),
        .core_msg_avail (core_msg_avail),
        .core_busy      (core_busy),
        .block_out      (block_out),
        .core_rate_out  (core_rate_out),
        .digest         (digest),
        .digest_valid   (digest_valid),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    // Toy permutation standing in for the SPONGENT core
    function automatic logic [63:0] core_step(input logic [63:0] s, input logic avail,
                                              input logic [15:0] blk);
        logic [63:0] t;
        t = s;
        if (avail) t[63:48] = t[63:48] ^ blk;
        t = (t ^ (t >> 29)) * 64'h9E3779B97F4A7C15 + 64'd1;
        return t ^ (t >> 31);
    endfunction

    // ---------------- core model ----------------
    logic [63:0] m_state     = '0;
    logic        m_busy      = 1'b0;
    int          m_cnt       = 0;
    int          hold_cycles = 2;
    logic        m_cur_avail = 1'b0;
    logic [15:0] m_cur_block = '0;
    blkq_t       abs_log;
    int          n_sq_starts = 0;

    assign core_busy     = m_busy;
    assign core_rate_out = m_busy ? 16'hDEAD : m_state[15:0];

    always @(posedge clk) begin
        if (reset || core_clear) begin
            m_state     <= '0;
            m_busy      <= 1'b0;
            m_cnt       <= 0;
            m_cur_avail <= 1'b0;
            n_sq_starts <= 0;
            abs_log.delete();
        end else if (core_start) begin
            m_state     <= core_step(m_state, core_msg_avail, block_out);
            m_busy      <= 1'b1;
            m_cnt       <= hold_cycles;
            m_cur_avail <= core_msg_avail;
            m_cur_block <= block_out;
            if (core_msg_avail) abs_log.push_back(block_out);
            else n_sq_starts <= n_sq_starts + 1;
        end else if (m_busy) begin
            if (m_cnt == 0) m_busy <= 1'b0;
            else m_cnt <= m_cnt - 1;
        end
    end

    // ---------------- protocol monitors ----------------
    int   err_start_busy = 0;
    int   err_no_busy    = 0;
    int   err_ready_busy = 0;
    int   err_stable     = 0;
    logic prev_start     = 1'b0;

    always @(negedge clk) begin
        if (core_start && core_busy) err_start_busy <= err_start_busy + 1;
        if (prev_start && !core_busy && !reset) err_no_busy <= err_no_busy + 1;
        if (in_ready && core_busy) err_ready_busy <= err_ready_busy + 1;
        if (core_busy && m_cur_avail && block_out !== m_cur_block) err_stable <= err_stable + 1;
        prev_start <= core_start;
    end

    // ---------------- reference model ----------------
    function automatic blkq_t ref_blocks(input byteq_t msg);
        blkq_t  r;
        byteq_t p;
        logic [15:0] w;
        p = msg;
        p.push_back(8'h80);
        while (p.size() % BPB != 0) p.push_back(8'h00);
        for (int i = 0; i < p.size(); i += BPB) begin
            w = '0;
            for (int j = 0; j < BPB; j++) w = (w << 8) | 16'(p[i+j]);
            r.push_back(w);
        end
        return r;
    endfunction

    function automatic logic [127:0] ref_digest(input blkq_t blks);
        logic [63:0]  s;
        logic [127:0] d;
        s = '0;
        d = '0;
        foreach (blks[i]) s = core_step(s, 1'b1, blks[i]);
        for (int i = 0; i < NSQ; i++) begin
            d = {d[111:0], s[15:0]};
            if (i < NSQ - 1) s = core_step(s, 1'b0, 16'h0);
        end
        return d;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Drive a message byte by byte; caller is positioned at a negedge
    task automatic send_msg(input byteq_t msg, input int gap_max);
        int t;
        for (int i = 0; i < msg.size(); i++) begin
            repeat ($urandom_range(0, gap_max)) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = msg[i];
            in_last  = (i == msg.size() - 1);
            t = 0;
            while (!in_ready && t < BOUND) begin
                @(negedge clk);
                t++;
            end
            if (!in_ready) begin
                chk("accept_timeout", 0, 1);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (!digest_valid && t < BOUND) begin
            @(negedge clk);
            t++;
        end
    endtask

    task automatic check_msg(input string nm, input byteq_t msg, input blkq_t exp_blks);
        chk({nm, "_n_absorb"}, abs_log.size(), exp_blks.size());
        for (int i = 0; i < exp_blks.size() && i < abs_log.size(); i++)
            chk({nm, "_block"}, abs_log[i], exp_blks[i]);
        chk({nm, "_sq_starts"}, n_sq_starts, NSQ - 1);
        chk({nm, "_digest"}, digest, ref_digest(ref_blocks(msg)));
        chk({nm, "_digest_valid"}, digest_valid, 1);
        chk({nm, "_busy_low"}, busy, 0);
    endtask

    task automatic check_idle_outputs(input string nm);
        chk({nm, "_ctl"}, {in_ready, core_clear, core_start, core_msg_avail, digest_valid, busy}, 0);
        chk({nm, "_block_out"}, block_out, 0);
        chk({nm, "_digest"}, digest, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        vec_t        vt[4];
        byteq_t      msg;
        blkq_t       eb;
        logic [31:0] tb_bytes;
        logic [47:0] tb_blks;
        int          t;

        vt[0] = '{1, 32'hAB000000, 1, 48'hAB80_0000_0000, 0};
        vt[1] = '{2, 32'h12340000, 2, 48'h1234_8000_0000, 1};
        vt[2] = '{3, 32'h12345600, 2, 48'h1234_5680_0000, 3};
        vt[3] = '{4, 32'h01020304, 3, 48'h0102_0304_8000, 2};

        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_last  = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b0;
        @(negedge clk);

        // Table-driven known messages
        for (int v = 0; v < 4; v++) begin
            msg.delete();
            eb.delete();
            tb_bytes = vt[v].bytes;
            tb_blks  = vt[v].blks;
            for (int j = 0; j < vt[v].len; j++) msg.push_back(tb_bytes[31-8*j -: 8]);
            for (int j = 0; j < vt[v].nblk; j++) eb.push_back(tb_blks[47-16*j -: 16]);
            hold_cycles = vt[v].hold;
            send_msg(msg, 0);
            wait_done();
            check_msg($sformatf("vec%0d", v), msg, eb);
            @(negedge clk);
        end

        // Back-to-back: new message while DONE
        in_valid = 1'b1;
        in_data  = 8'hC3;
        in_last  = 1'b1;
        @(negedge clk);
        chk("b2b_valid_drop", digest_valid, 0);
        chk("b2b_clear_pulse", core_clear, 1);
        @(negedge clk);
        chk("b2b_settle1", in_ready, 0);
        @(negedge clk);
        chk("b2b_settle2", in_ready, 0);
        @(negedge clk);
        chk("b2b_fill_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        msg = '{8'hC3};
        wait_done();
        check_msg("b2b", msg, ref_blocks(msg));
        @(negedge clk);

        // Gapped input with a long core busy
        hold_cycles = 19;
        msg = '{8'h12, 8'h34, 8'h56};
        eb  = '{16'h1234, 16'h5680};
        send_msg(msg, 3);
        wait_done();
        check_msg("slow_core", msg, eb);
        @(negedge clk);

        // Reset while waiting on a squeeze
        hold_cycles = 5;
        msg = '{8'h5A};
        send_msg(msg, 0);
        t = 0;
        while (!(n_sq_starts >= 2 && core_busy && !core_start) && t < BOUND) begin
            @(negedge clk);
            t++;
        end
        chk("sq_wait_reached", core_busy, 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_idle_outputs("mid_reset");
        reset = 1'b0;
        @(negedge clk);
        hold_cycles = 1;
        msg = '{8'h9E, 8'h01, 8'h77};
        send_msg(msg, 1);
        wait_done();
        check_msg("after_reset", msg, ref_blocks(msg));
        @(negedge clk);

        // Randomized messages
        for (int r = 0; r < 10; r++) begin
            msg.delete();
            repeat ($urandom_range(1, 9)) msg.push_back(8'($urandom));
            hold_cycles = $urandom_range(0, 4);
            send_msg(msg, 2);
            wait_done();
            check_msg($sformatf("rand%0d", r), msg, ref_blocks(msg));
            @(negedge clk);
        end

        chk("start_while_busy", err_start_busy, 0);
        chk("start_without_busy", err_no_busy, 0);
        chk("ready_while_busy", err_ready_busy, 0);
        chk("block_stable", err_stable, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
